note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_player_pkg.sv | 19 +
 rtl/byte_fifo.sv | 65 ++++++
 rtl/note_player.sv | 141 ++++++++++++++
 tb/tb_note_player.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared definitions for the note player and the tone generator.
//   player_state_t : FSM state encoding (IDLE / PLAY / GAP)
//   NOTE_SILENCE   : note code meaning "no tone"
//   max_int        : elaboration-time helper for sizing counters
package note_player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } player_state_t;

  localparam logic [7:0] NOTE_SILENCE = 8'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write strobe and data; ignored while full
//   pop, dout  : read strobe and head-of-queue data; pop ignored while empty
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags derived from count
// dout is a combinational read of the head entry so that the consumer can
// capture the byte in the same cycle it pops it.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = count_reg;

  // Storage carries no reset; stale entries are never read because the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/note_player.sv
// Queues received note bytes and plays them one at a time: each note is
// held for NOTE_CYCLES, followed by GAP_CYCLES of silence.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_data      : received byte (note code, 0x00 = rest)
//   in_valid     : one-cycle strobe qualifying in_data
//   note         : note code for the tone generator, 0x00 = silence
//   note_valid   : one-cycle strobe whenever note changes
//   playing      : high while in PLAY or GAP
//   count        : FIFO occupancy
//   overflow     : sticky, set when a byte arrives while the FIFO is full
module note_player
  import note_player_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic [7:0]               note,
  output logic                     note_valid,
  output logic                     playing,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int DUR_MAX = max_int(NOTE_CYCLES, GAP_CYCLES);
  localparam int TW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

  player_state_t state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]    note_reg, note_next;
  logic          note_valid_reg, note_valid_next;
  logic          overflow_reg;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  // Full is judged on the registered count, so a byte arriving in the same
  // cycle as a pop from a full FIFO is still dropped.
  assign fifo_push = in_valid && !fifo_full;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (in_valid && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      note_reg       <= NOTE_SILENCE;
      note_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      note_reg       <= note_next;
      note_valid_reg <= note_valid_next;
    end
  end

  // The timer restarts at 0 on every state entry; the entry cycle is the
  // note_valid cycle, so it counts as the first cycle of PLAY or GAP.
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    note_next       = note_reg;
    note_valid_next = 1'b0;
    fifo_pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          note_next       = fifo_dout;
          note_valid_next = 1'b1;
          state_next      = PLAY;
        end
      end
      PLAY: begin
        if (timer_reg == TW'(NOTE_CYCLES - 1)) begin
          timer_next      = '0;
          note_next       = NOTE_SILENCE;
          note_valid_next = 1'b1;
          state_next      = GAP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      GAP: begin
        if (timer_reg == TW'(GAP_CYCLES - 1)) begin
          timer_next = '0;
          if (!fifo_empty) begin
            // Chain straight into the next note without an IDLE cycle.
            fifo_pop        = 1'b1;
            note_next       = fifo_dout;
            note_valid_next = 1'b1;
            state_next      = PLAY;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
        note_next  = NOTE_SILENCE;
      end
    endcase
  end

  assign note       = note_reg;
  assign note_valid = note_valid_reg;
  assign playing    = (state_reg == PLAY) || (state_reg == GAP);
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player (DEPTH=4, NOTE_CYCLES=10, GAP_CYCLES=3).
// Stimulus pushes {cycle, note} expectations; a negedge monitor pops and
// compares on every note_valid strobe.
module tb_note_player;

  localparam int DEPTH = 4;
  localparam int NC    = 10;
  localparam int GC    = 3;
  localparam int PER   = NC + GC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] note;
  logic       note_valid;
  logic       playing;
  logic [2:0] count;
  logic       overflow;

  typedef struct {
    int         cyc;
    logic [7:0] nt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_nv = 1'b0;

  note_player #(
    .DEPTH       (DEPTH),
    .NOTE_CYCLES (NC),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .note       (note),
    .note_valid (note_valid),
    .playing    (playing),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every note_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && note_valid) begin
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_note_valid: cyc=%0d note=%02h, none expected", cyc, note);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.nt !== note) begin
          errors = errors + 1;
          $display("FAIL note_event: got cyc=%0d note=%02h, expected cyc=%0d note=%02h",
                   cyc, note, e.cyc, e.nt);
        end else begin
          $display("note_valid cyc=%0d note=%02h ok", cyc, note);
        end
      end
      checks = checks + 1;
      if (prev_nv) begin
        errors = errors + 1;
        $display("FAIL note_valid_spacing: high on consecutive cycles at cyc=%0d, expected single", cyc);
      end
    end
    prev_nv = rst_n && note_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic expect_nv(input int c, input logic [7:0] n);
    exp_t e;
    e.cyc = c;
    e.nt  = n;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_until(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_drain: got %0d pending events expected 0", name, q.size());
      q.delete();
    end
    idle(GC + 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0;
    int n;
    #1;
    chk("reset_note", note, 0);
    chk("reset_note_valid", note_valid, 0);
    chk("reset_playing", playing, 0);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Single byte
    t0 = cyc;
    expect_nv(t0 + 2, 8'h41);
    expect_nv(t0 + 12, 8'h00);
    send(8'h41);
    wait_until(t0 + 14);
    chk("single_playing_c14", playing, 1);
    wait_until(t0 + 15);
    chk("single_playing_c15", playing, 0);
    wait_drain("single", 40);

    // Back-to-back
    t0 = cyc;
    expect_nv(t0 + 2, 8'h41);
    expect_nv(t0 + 12, 8'h00);
    expect_nv(t0 + 15, 8'h43);
    expect_nv(t0 + 25, 8'h00);
    send(8'h41);
    send(8'h43);
    wait_until(t0 + 28);
    chk("b2b_count", count, 0);
    chk("b2b_playing", playing, 0);
    wait_drain("b2b", 40);

    // Overflow: six consecutive bytes, sixth dropped
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      expect_nv(t0 + 2 + PER * k, 8'h10 + 8'(k));
      expect_nv(t0 + 12 + PER * k, 8'h00);
    end
    for (int k = 0; k < 6; k++) send(8'h10 + 8'(k));
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    wait_until(t0 + 2 + PER * 5);
    chk("ovf_count_end", count, 0);
    chk("ovf_playing_end", playing, 0);
    wait_drain("ovf", 100);

    do_reset();
    chk("rst_clears_overflow", overflow, 0);

    // Rest byte
    t0 = cyc;
    expect_nv(t0 + 2, 8'h00);
    expect_nv(t0 + 12, 8'h00);
    send(8'h00);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (playing) n++;
      tick();
    end
    chk("rest_playing_cycles", n, 13);
    wait_drain("rest", 20);

    // Reset mid-PLAY with two bytes queued
    t0 = cyc;
    expect_nv(t0 + 2, 8'h41);
    send(8'h41);
    send(8'h43);
    send(8'h45);
    wait_until(t0 + 5);
    chk("midplay_count", count, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_note", note, 0);
    chk("midrst_note_valid", note_valid, 0);
    chk("midrst_playing", playing, 0);
    chk("midrst_count", count, 0);
    chk("midrst_overflow", overflow, 0);
    idle(2);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (note_valid) n++;
    end
    chk("post_reset_quiet", n, 0);
    chk("post_reset_queue_consumed", q.size(), 0);
    q.delete();

    // Full FIFO with a byte arriving on the GAP-end pop
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      expect_nv(t0 + 2 + PER * k, 8'h50 + 8'(k));
      expect_nv(t0 + 12 + PER * k, 8'h00);
    end
    for (int k = 0; k < 5; k++) send(8'h50 + 8'(k));
    wait_until(t0 + 13);
    chk("fullpop_count_before", count, 4);
    chk("fullpop_overflow_before", overflow, 0);
    wait_until(t0 + 14);
    send(8'h55);
    chk("fullpop_count_after", count, 3);
    chk("fullpop_overflow_after", overflow, 1);
    wait_drain("fullpop", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
